rr_arb_lock: RTL
================

Name: rr_arb_lock

Overview:
- Round-robin arbiter with packet locking for sharing one NoC output channel among N_INPUT requesters.
- Picks one requester per packet and holds the grant until that requester's tail flit handshakes.
- Publishes the grant both one-hot and as a binary index, so downstream payload muxes can use either.
- Sits between input-port request logic and the output channel register.

Parameters:
- N_INPUT, 4, number of requesters; must be ≥1.
- N_INPUT_WIDTH, derived (localparam): $clog2(N_INPUT) when N_INPUT > 1, else 1. Index width.

Ports:
- clk  in  1  sole clock.
- rstn  in  1  reset; synchronous, active-low.
- req_vld_i  in  N_INPUT  per-requester flit valid.
- req_tail_i  in  N_INPUT  per-requester flag: the current flit is the last flit of its packet.
- req_rdy_o  out  N_INPUT  per-requester ready; one-hot or zero.
- gnt_vld_o  out  1  channel valid, meaning some requester is selected.
- gnt_tail_o  out  1  tail flag of the selected requester.
- gnt_rdy_i  in  1  channel ready from downstream.
- gnt_oh_o  out  N_INPUT  one-hot selection; zero when idle.
- gnt_idx_o  out  N_INPUT_WIDTH  binary index of gnt_oh_o; 0 when idle.

Behaviour:
- State:
  - FSM: IDLE / LOCKED.
  - owner_oh register, N_INPUT bits.
  - prio_ptr_oh register, N_INPUT bits: one-hot, marks the highest-priority requester.
- Reset (rstn=0 at a clk edge):
  - FSM goes to IDLE, owner_oh=0, prio_ptr_oh=1 (requester 0 has priority).
  - Outputs follow combinationally: all zero while no request; req_rdy_o=0 while rstn=0.
- IDLE:
  - sel_oh = first set bit of req_vld_i, searching circularly from prio_ptr_oh upward with wrap N_INPUT-1 → 0.
  - Selection is combinational with zero latency: gnt_vld_o=|req_vld_i, gnt_oh_o=sel_oh.
- LOCKED:
  - sel_oh = owner_oh.
  - gnt_vld_o = |(req_vld_i & owner_oh); other requesters are ignored even when owner is idle.
- Common outputs:
  - gnt_tail_o = |(req_tail_i & sel_oh).
  - req_rdy_o = sel_oh & {N{gnt_rdy_i}}, gated by gnt_vld_o.
- Handshake: hs = gnt_vld_o & gnt_rdy_i.
- Transitions:
  - IDLE, hs & !gnt_tail_o → LOCKED, owner_oh ← sel_oh.
  - IDLE, hs & gnt_tail_o → single-flit packet; stay IDLE.
  - LOCKED, hs & gnt_tail_o → IDLE, owner_oh ← 0.
  - Otherwise the state holds.
- Pointer update: only on a tail handshake, prio_ptr_oh ← rotate-left-by-1(sel_oh), wrapping bit N-1 → bit 0.
- Boundaries:
  - gnt_rdy_i low in IDLE: selection may change cycle to cycle; no lock is taken without hs.
  - Owner deasserts valid mid-packet: the lock holds, gnt_vld_o=0.
  - N_INPUT=1: the pointer stays 1 and gnt_idx_o=0.
- Index encoding: gnt_idx_o bit i = OR over j of (gnt_oh_o[j] & bit i of j).

Optional Feature:
- Macro: RR_ARB_PRIO_EN.
- Defined:
  - Adds input req_prio_i [N_INPUT].
  - IDLE arbitration first considers req_vld_i & req_prio_i. If that set is nonzero it is arbitrated alone, using the same circular search from the same prio_ptr_oh; otherwise all of req_vld_i is arbitrated.
  - A lock is never preempted by priority.
- Undefined: port absent; plain round-robin.

Decomposition:
- Package rr_arb_pkg:
  - arb_state_e enum {IDLE, LOCKED}.
  - function rotl1_oh.
- Sub-module: oh2idx instance for gnt_oh_o → gnt_idx_o.
- Circular first-one search stays in-module as a doubled-vector mask/priority.

Test Plan (N_INPUT=4):
- Reset, then req_vld_i=4'b1111, all tails=1, gnt_rdy_i=1 for 4 cycles → gnt_idx_o sequence 0,1,2,3; req_rdy_o 0001,0010,0100,1000.
- Req 1 sends a 3-flit packet (tail on the 3rd flit) while req 2 is valid throughout → gnt_idx_o=1 for 3 handshakes, then 2; prio_ptr_oh=4'b0100 after the tail.
- Locked on req 1 after its first flit; req 1 deasserts valid for 2 cycles, req 3 valid → gnt_vld_o=0, req_rdy_o=0 for those cycles, and the lock resumes on req 1.
- gnt_rdy_i=0 for 3 cycles with req_vld_i=4'b0101 → FSM stays IDLE; no pointer change; gnt_oh_o=0001 stable; after gnt_rdy_i=1 and a tail handshake, the pointer becomes 0010.
- Assert rstn=0 for one cycle while LOCKED on req 2 → next cycle IDLE, pointer 0001, grant goes to the lowest valid index.
- RR_ARB_PRIO_EN: req_vld_i=1111, req_prio_i=1000, pointer 0001, single-flit packets → grant idx 3; with prio then dropped, next grant idx 0.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the packet-locking round-robin arbiter.
package rr_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Widest one-hot vector rotl1_oh can handle; callers cast to their own width.
  localparam int OH_MAX_W = 64;

  // Rotate an n-bit one-hot left by one, bit n-1 wrapping to bit 0.
  function automatic logic [OH_MAX_W-1:0] rotl1_oh(input logic [OH_MAX_W-1:0] v,
                                                   input int unsigned n);
    logic [OH_MAX_W-1:0] keep;
    keep = (OH_MAX_W'(1) << n) - OH_MAX_W'(1);
    return ((v << 1) | (v >> (n - 1))) & keep;
  endfunction

endpackage

// File: rtl/oh2idx.sv
// One-hot to binary index encoder; all-zero input yields index 0.
module oh2idx #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] oh,
  output logic [W-1:0] idx
);

  logic [W-1:0][N-1:0] term;

  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    for (genvar gj = 0; gj < N; gj++) begin : g_src
      localparam int unsigned SRC = gj;
      assign term[gi][gj] = oh[gj] & SRC[gi];
    end
    assign idx[gi] = |term[gi];
  end

endmodule

// File: rtl/rr_arb_lock.sv
// Round-robin arbiter that locks the grant for a whole packet (until tail handshake).
// Optional macro RR_ARB_PRIO_EN adds req_prio_i for a high-priority arbitration tier.
module rr_arb_lock
  import rr_arb_pkg::*;
#(
  parameter int N_INPUT = 4,
  localparam int N_INPUT_WIDTH = (N_INPUT > 1) ? $clog2(N_INPUT) : 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [N_INPUT-1:0]       req_vld_i,
  input  logic [N_INPUT-1:0]       req_tail_i,
`ifdef RR_ARB_PRIO_EN
  input  logic [N_INPUT-1:0]       req_prio_i,
`endif
  output logic [N_INPUT-1:0]       req_rdy_o,
  output logic                     gnt_vld_o,
  output logic                     gnt_tail_o,
  input  logic                     gnt_rdy_i,
  output logic [N_INPUT-1:0]       gnt_oh_o,
  output logic [N_INPUT_WIDTH-1:0] gnt_idx_o
);

  arb_state_e         state_reg, state_next;
  logic [N_INPUT-1:0] owner_oh_reg, owner_oh_next;
  logic [N_INPUT-1:0] prio_ptr_oh_reg, prio_ptr_oh_next;

  logic [N_INPUT-1:0]   arb_vld;
  logic [N_INPUT-1:0]   below_ptr;
  logic [N_INPUT-1:0]   search_oh;
  logic [2*N_INPUT-1:0] dbl_vld;
  logic [2*N_INPUT-1:0] dbl_first;
  logic [N_INPUT-1:0]   sel_oh;
  logic                 gnt_vld;
  logic                 gnt_tail;
  logic                 hs;

`ifdef RR_ARB_PRIO_EN
  logic [N_INPUT-1:0] hi_vld;
  assign hi_vld  = req_vld_i & req_prio_i;
  assign arb_vld = (|hi_vld) ? hi_vld : req_vld_i;
`else
  assign arb_vld = req_vld_i;
`endif

  // Lower half holds requesters at/above the pointer, upper half all of them,
  // so the lowest set bit of the doubled vector is the circular winner.
  assign below_ptr = prio_ptr_oh_reg - N_INPUT'(1);
  assign dbl_vld   = {arb_vld, arb_vld & ~below_ptr};
  assign dbl_first = dbl_vld & (-dbl_vld);
  assign search_oh = dbl_first[N_INPUT-1:0] | dbl_first[2*N_INPUT-1:N_INPUT];

  always_comb begin
    state_next       = state_reg;
    owner_oh_next    = owner_oh_reg;
    prio_ptr_oh_next = prio_ptr_oh_reg;
    sel_oh           = '0;
    gnt_vld          = 1'b0;

    case (state_reg)
      IDLE: begin
        sel_oh  = search_oh;
        gnt_vld = |req_vld_i;
      end
      LOCKED: begin
        sel_oh  = owner_oh_reg;
        gnt_vld = |(req_vld_i & owner_oh_reg);
      end
      default: begin
        sel_oh  = '0;
        gnt_vld = 1'b0;
      end
    endcase

    gnt_tail = |(req_tail_i & sel_oh);
    hs       = gnt_vld & gnt_rdy_i;

    if (hs) begin
      if (gnt_tail) begin
        state_next       = IDLE;
        owner_oh_next    = '0;
        prio_ptr_oh_next = N_INPUT'(rotl1_oh(OH_MAX_W'(sel_oh), N_INPUT));
      end else if (state_reg == IDLE) begin
        state_next    = LOCKED;
        owner_oh_next = sel_oh;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg       <= IDLE;
      owner_oh_reg    <= '0;
      prio_ptr_oh_reg <= N_INPUT'(1);
    end else begin
      state_reg       <= state_next;
      owner_oh_reg    <= owner_oh_next;
      prio_ptr_oh_reg <= prio_ptr_oh_next;
    end
  end

  assign gnt_vld_o  = gnt_vld;
  assign gnt_tail_o = gnt_tail;
  assign gnt_oh_o   = sel_oh;
  assign req_rdy_o  = sel_oh & {N_INPUT{gnt_rdy_i & gnt_vld & rstn}};

  oh2idx #(
    .N (N_INPUT),
    .W (N_INPUT_WIDTH)
  ) u_oh2idx (
    .oh  (sel_oh),
    .idx (gnt_idx_o)
  );

endmodule
